// File: rtl/td4_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : td4_prog_loader
//  Purpose  : Byte-stream program loader and 16-word instruction store for the
//             TD4 core; holds the core off (cpu_run) until a full image lands.
//  Revision : 1.0 - initial release
// ============================================================================
module td4_prog_loader #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_start,
    input  logic          wr_valid,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ready,
    input  logic [AW-1:0] pc,
    output logic [DW-1:0] instr,
    output logic          cpu_run,
    output logic          load_done,
    output logic [7:0]    checksum
);

    localparam logic [1:0]    c_st_empty  = 2'd0;
    localparam logic [1:0]    c_st_load   = 2'd1;
    localparam logic [1:0]    c_st_run    = 2'd2;
    localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);

    logic [1:0]    r_state;
    logic [1:0]    w_state_next;
    logic [AW-1:0] r_wr_ptr;
    logic [7:0]    r_checksum;
    logic          r_load_done;
    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_mem [DEPTH];
    logic          w_xfer;
    logic          w_last;

    // load_start wins over a byte presented in the same cycle
    assign w_xfer = wr_valid && wr_ready && !load_start;
    assign w_last = w_xfer && (r_wr_ptr == c_last_addr);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_empty;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_empty: ;
            c_st_load:  if (w_last) w_state_next = c_st_run;
            c_st_run:   ;
            default:    w_state_next = c_st_empty;
        endcase
        if (load_start) begin
            w_state_next = c_st_load;
        end
    end

    // ---------------- FSM: output logic ----------------
    always_comb begin
        wr_ready = 1'b0;
        cpu_run  = 1'b0;
        case (r_state)
            c_st_load: wr_ready = 1'b1;
            c_st_run:  cpu_run  = 1'b1;
            default:   ;
        endcase
    end

    // ---------------- Write pointer, checksum, completion pulse ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_checksum  <= 8'h00;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_last;
            if (load_start) begin
                r_wr_ptr   <= '0;
                r_checksum <= 8'h00;
            end else if (w_xfer) begin
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_checksum <= r_checksum + 8'(wr_data);
            end
        end
    end

    // ---------------- Program store ----------------
    // Restarting a load keeps old words; only reset clears the image.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_xfer) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // ---------------- Instruction fetch ----------------
    // Outside RUN the core sees 0x00 (ADD A,0), which is a harmless no-op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= '0;
        end else begin
            r_instr <= (r_state == c_st_run) ? r_mem[pc] : '0;
        end
    end

    assign instr     = r_instr;
    assign load_done = r_load_done;
    assign checksum  = r_checksum;

endmodule
`default_nettype wire

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
- Program memory and loader that sits directly upstream of the TD4 core inside tt_um_TD4_Assy_KosugiSubaru.
- Accepts a byte stream from the pins, fills a 16-word instruction ROM-equivalent, then serves instruction fetches addressed by the core's 4-bit PC.
- Gates the core's execution with cpu_run until a complete image has been loaded.

Parameters:
- DEPTH, 16, number of program words; must be a power of two.
- AW, 4, address width; equals log2(DEPTH) and matches the TD4 PC width.
- DW, 8, instruction word width.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_start  input  1  single-cycle request to (re)start loading an image.
- wr_valid  input  1  wr_data holds a valid program byte.
- wr_data  input  DW  program byte.
- wr_ready  output  1  loader accepts a byte this cycle.
- pc  input  AW  fetch address from the core.
- instr  output  DW  registered instruction word.
- cpu_run  output  1  image complete; core may execute.
- load_done  output  1  one-cycle pulse when the last byte is written.
- checksum  output  8  running mod-256 sum of the bytes accepted since the last load_start.

Behaviour:
- Reset (rst sampled high at a clock edge):
  - all memory words = 0x00; wr_ptr = 0; state = EMPTY.
  - wr_ready = 0, cpu_run = 0, load_done = 0, checksum = 0x00, instr = 0x00.
- States: EMPTY, LOAD, RUN.
  - EMPTY: wr_ready = 0, cpu_run = 0. load_start goes to LOAD.
  - LOAD: wr_ready = 1, cpu_run = 0.
  - RUN: wr_ready = 0, cpu_run = 1. load_start goes to LOAD.
- load_start is honoured in any state, including LOAD, where it restarts the load. On the edge that samples it:
  - state <= LOAD, wr_ptr <= 0, checksum <= 0.
  - Memory contents are retained; they are overwritten as new bytes arrive.
- Write handshake:
  - A byte transfers on any edge where wr_valid && wr_ready && !load_start.
  - load_start has priority: a byte presented in the same cycle is dropped.
  - On transfer: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr + 1 (AW bits, wraps); checksum <= checksum + wr_data, truncated to 8 bits.
  - Gaps in wr_valid are allowed; there is no timeout.
- Completion:
  - The transfer at wr_ptr == DEPTH-1 moves the state to RUN on the same edge.
  - load_done = 1 for exactly the following cycle; cpu_run = 1 and wr_ready = 0 from that cycle onward.
  - wr_ptr wraps to 0.
- Fetch:
  - instr <= (state == RUN) ? mem[pc] : 0x00 on every edge, giving 1-cycle latency.
  - 0x00 decodes in the core as ADD A,0, which is harmless.
  - The first RUN-state fetch is sampled on the edge after load_done asserts.
- No memory write can occur in RUN, so there is no read/write collision.
- Reset mid-LOAD: reset wins over everything, memory is cleared, and the partial image is discarded.
- wr_valid in EMPTY or RUN: ignored; wr_ready stays 0 and nothing is written.
- Simultaneous rst and load_start: reset wins.
- checksum is held after completion until the next load_start or reset.

Test Plan:
- Reset values:
  - Hold rst for 2 cycles with random inputs.
  - Require wr_ready = 0, cpu_run = 0, load_done = 0, checksum = 0x00, instr = 0x00.
  - Drive wr_valid = 1 in EMPTY; require no write, confirmed by a later load of zeros and reading back 0x00.
- Back-to-back load:
  - Pulse load_start, then wr_valid = 1 for 16 cycles with bytes 0x10..0x1F.
  - Require load_done high exactly 1 cycle after the 16th transfer, then cpu_run = 1 and checksum = 0x78.
  - Drive pc = 5; require instr = 0x15 one cycle later.
  - Sweep pc 0..15; require instr = 0x10+pc one cycle after each.
- Gapped load:
  - Same bytes with wr_valid toggling 1/0.
  - Require the same final contents and checksum 0x78, and cpu_run rising only after the 16th accepted byte.
- Restart mid-load:
  - After 7 bytes of 0xFF, pulse load_start together with wr_valid = 1 carrying 0xAA; require 0xAA to be dropped and checksum = 0x00.
  - Load 16 bytes of 0x01; require checksum = 0x10 and every fetch to return 0x01.
- Reload from RUN:
  - In RUN, pulse load_start.
  - Require cpu_run = 0 and instr = 0x00 on the following cycles, wr_ready = 1, and old contents replaced by the new image after completion.
- Reset mid-load:
  - Assert rst after 9 bytes.
  - Require all outputs at reset values; a subsequent full load of 0x20..0x2F reads back correctly with checksum 0x78.
